// File: rtl/lsu_pkg.sv
// Load/store unit shared types: FSM states, access sizes, mask constants,
// and the helpers that classify and align an access.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } lsu_state_e;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } lsu_size_e;

  localparam logic [3:0] MASK_B = 4'b0001;
  localparam logic [3:0] MASK_H = 4'b0011;
  localparam logic [3:0] MASK_W = 4'b1111;

  // Any mask other than byte/half is treated as a word access
  function automatic lsu_size_e size_of(input logic [3:0] mask);
    case (mask)
      MASK_B:  return SZ_B;
      MASK_H:  return SZ_H;
      default: return SZ_W;
    endcase
  endfunction

  function automatic logic [3:0] size_mask(input lsu_size_e sz);
    case (sz)
      SZ_B:    return MASK_B;
      SZ_H:    return MASK_H;
      default: return MASK_W;
    endcase
  endfunction

  function automatic logic is_misaligned(input lsu_size_e sz, input logic [1:0] off);
    return ((sz == SZ_H) && off[0]) || ((sz == SZ_W) && (off != 2'b00));
  endfunction

  // Drop the offset bits that would make the access cross its natural boundary
  function automatic logic [1:0] force_align(input lsu_size_e sz, input logic [1:0] off);
    case (sz)
      SZ_H:    return {off[1], 1'b0};
      SZ_W:    return 2'b00;
      default: return off;
    endcase
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Data-memory req/ack bus between the load/store unit (master) and memory (slave).
interface lsu_if #(
  parameter int unsigned ADDR_WIDTH = 32
) ();

  logic                  mem_req_o;
  logic                  mem_we_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic [3:0]            mem_wmask_o;
  logic [31:0]           mem_wdata_o;
  logic                  mem_ack_i;
  logic [31:0]           mem_rdata_i;

  modport master (
    output mem_req_o, mem_we_o, mem_addr_o, mem_wmask_o, mem_wdata_o,
    input  mem_ack_i, mem_rdata_i
  );

  modport slave (
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wmask_o, mem_wdata_o,
    output mem_ack_i, mem_rdata_i
  );

endinterface

// File: rtl/lsu_align.sv
// Byte-lane alignment: store-side lane shift and write mask, load-side
// shift down and sign/zero extension. Purely combinational.
module lsu_align
  import lsu_pkg::*;
(
  input  logic        i_st_we,
  input  lsu_size_e   i_st_size,
  input  logic [1:0]  i_st_off,
  input  logic [31:0] i_st_wdata,
  output logic [3:0]  o_st_wmask,
  output logic [31:0] o_st_wdata,
  input  lsu_size_e   i_ld_size,
  input  logic [1:0]  i_ld_off,
  input  logic        i_ld_sext,
  input  logic [31:0] i_ld_rdata,
  output logic [31:0] o_ld_data
);

  logic [3:0]  w_mask;
  logic [31:0] w_r;

  // Store lanes: move LSB-justified data and size mask up to the byte offset
  always_comb begin
    w_mask     = size_mask(i_st_size);
    o_st_wmask = i_st_we ? (w_mask << i_st_off) : 4'b0000;
    o_st_wdata = i_st_wdata << {i_st_off, 3'b000};
  end

  // Load lanes: bring the addressed bytes down to bit 0 and extend
  always_comb begin
    w_r = i_ld_rdata >> {i_ld_off, 3'b000};
    case (i_ld_size)
      SZ_B:    o_ld_data = {{24{i_ld_sext & w_r[7]}}, w_r[7:0]};
      SZ_H:    o_ld_data = {{16{i_ld_sext & w_r[15]}}, w_r[15:0]};
      default: o_ld_data = w_r;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one data-memory access per decoder request over a req/ack
// bus, stalling the core until the access completes.
// Optional feature macro MISALIGN_TRAP_EN: misaligned accesses skip the bus
// and raise misalign_o; otherwise the offending offset bits are forced to 0.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic        clk,
  input  logic        reset_n_i,
  input  logic        addr_valid_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [3:0]  mask_i,
  input  logic        sext_i,
  input  logic [31:0] wdata_i,
  lsu_if.master       mem,
  output logic        stall_o,
  output logic [31:0] load_data_o,
  output logic        load_valid_o,
  output logic        misalign_o
);

  lsu_state_e r_state, w_next;

  logic                  r_we;
  logic                  r_sext;
  logic                  r_mis;
  lsu_size_e             r_size;
  logic [1:0]            r_off;
  logic                  r_mem_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [3:0]            r_wmask;
  logic [31:0]           r_wdata;
  logic [31:0]           r_ld_data;

  lsu_size_e   w_size;
  logic [1:0]  w_off;
  logic        w_trap;
  logic        w_start;
  logic        w_stall;
  logic [3:0]  w_st_wmask;
  logic [31:0] w_st_wdata;
  logic [31:0] w_ld_data;

  assign w_size  = size_of(mask_i);
  assign w_start = (r_state == IDLE) && addr_valid_i;

`ifdef MISALIGN_TRAP_EN
  assign w_off  = addr_i[1:0];
  assign w_trap = is_misaligned(w_size, addr_i[1:0]);
`else
  assign w_off  = force_align(w_size, addr_i[1:0]);
  assign w_trap = 1'b0;
`endif

  lsu_align u_align (
    .i_st_we    (we_i),
    .i_st_size  (w_size),
    .i_st_off   (w_off),
    .i_st_wdata (wdata_i),
    .o_st_wmask (w_st_wmask),
    .o_st_wdata (w_st_wdata),
    .i_ld_size  (r_size),
    .i_ld_off   (r_off),
    .i_ld_sext  (r_sext),
    .i_ld_rdata (mem.mem_rdata_i),
    .o_ld_data  (w_ld_data)
  );

  // State register
  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) r_state <= IDLE;
    else            r_state <= w_next;
  end

  // Next state and stall; DONE always returns to IDLE so a still-high
  // addr_valid_i for the same instruction cannot launch a second access
  always_comb begin
    w_next  = r_state;
    w_stall = 1'b0;
    case (r_state)
      IDLE: begin
        if (addr_valid_i) begin
          w_stall = 1'b1;
          w_next  = w_trap ? DONE : REQ;
        end
      end
      REQ: begin
        w_stall = 1'b1;
        if (mem.mem_ack_i) w_next = DONE;
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Request latch, registered bus outputs and captured load result
  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_we      <= 1'b0;
      r_sext    <= 1'b0;
      r_mis     <= 1'b0;
      r_size    <= SZ_B;
      r_off     <= 2'b00;
      r_mem_we  <= 1'b0;
      r_addr    <= '0;
      r_wmask   <= '0;
      r_wdata   <= '0;
      r_ld_data <= '0;
    end else begin
      if (w_start) begin
        r_we   <= we_i;
        r_sext <= sext_i;
        r_mis  <= w_trap;
        r_size <= w_size;
        r_off  <= w_off;
        if (!w_trap) begin
          r_mem_we <= we_i;
          r_addr   <= {addr_i[ADDR_WIDTH-1:2], 2'b00};
          r_wmask  <= w_st_wmask;
          r_wdata  <= w_st_wdata;
        end
      end
      if ((r_state == REQ) && mem.mem_ack_i && !r_we) begin
        r_ld_data <= w_ld_data;
      end
    end
  end

  assign mem.mem_req_o   = (r_state == REQ);
  assign mem.mem_we_o    = r_mem_we;
  assign mem.mem_addr_o  = r_addr;
  assign mem.mem_wmask_o = r_wmask;
  assign mem.mem_wdata_o = r_wdata;

  assign stall_o      = w_stall;
  assign load_data_o  = r_ld_data;
  assign load_valid_o = (r_state == DONE) && !r_we && !r_mis;

`ifdef MISALIGN_TRAP_EN
  assign misalign_o = (r_state == DONE) && r_mis;
`else
  assign misalign_o = 1'b0;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed vector table, random
// accesses against a behavioural model, and a reset-during-access sequence.
module tb_load_store_unit;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  mask;
    logic        sext;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int unsigned delay;
    logic        exp_mis;
    logic [31:0] exp_addr;
    logic [3:0]  exp_wmask;
    logic [31:0] exp_wdata;
    logic [31:0] exp_ld;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset_n_i;
  logic        addr_valid_i;
  logic        we_i;
  logic [31:0] addr_i;
  logic [3:0]  mask_i;
  logic        sext_i;
  logic [31:0] wdata_i;
  logic        stall_o;
  logic [31:0] load_data_o;
  logic        load_valid_o;
  logic        misalign_o;

  int unsigned checks = 0;
  int unsigned errors = 0;

  lsu_if #(.ADDR_WIDTH(32)) mem ();

  load_store_unit #(.ADDR_WIDTH(32)) dut (
    .clk          (clk),
    .reset_n_i    (reset_n_i),
    .addr_valid_i (addr_valid_i),
    .we_i         (we_i),
    .addr_i       (addr_i),
    .mask_i       (mask_i),
    .sext_i       (sext_i),
    .wdata_i      (wdata_i),
    .mem          (mem),
    .stall_o      (stall_o),
    .load_data_o  (load_data_o),
    .load_valid_o (load_valid_o),
    .misalign_o   (misalign_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Reference: expected bus/result values straight from the lane rules
  function automatic vec_t model(input vec_t v);
    vec_t        e;
    int unsigned off;
    int unsigned nb;
    logic        mis;
    logic [31:0] r;
    e   = v;
    off = v.addr % 4;
    nb  = (v.mask == 4'b0001) ? 1 : (v.mask == 4'b0011) ? 2 : 4;
    mis = ((nb == 2) && (off % 2 == 1)) || ((nb == 4) && (off != 0));
`ifdef MISALIGN_TRAP_EN
    e.exp_mis = mis;
`else
    e.exp_mis = 1'b0;
    if (mis) off = (nb == 2) ? (off & 2) : 0;
`endif
    e.exp_addr  = v.addr & 32'hFFFF_FFFC;
    e.exp_wmask = v.we ? 4'(((1 << nb) - 1) << off) : 4'd0;
    e.exp_wdata = v.wdata << (8 * off);
    r = v.rdata >> (8 * off);
    if (nb == 1) begin
      e.exp_ld = r & 32'hFF;
      if (v.sext && (e.exp_ld >= 32'h80)) e.exp_ld = e.exp_ld + 32'hFFFF_FF00;
    end else if (nb == 2) begin
      e.exp_ld = r & 32'hFFFF;
      if (v.sext && (e.exp_ld >= 32'h8000)) e.exp_ld = e.exp_ld + 32'hFFFF_0000;
    end else begin
      e.exp_ld = r;
    end
    return e;
  endfunction

  // One complete access from the decoder's side, memory answering after v.delay wait cycles
  task automatic apply(input vec_t v, input string tag);
    int unsigned n_stall;
    n_stall = 0;
    @(negedge clk);
    addr_valid_i = 1'b1;
    we_i = v.we; addr_i = v.addr; mask_i = v.mask; sext_i = v.sext; wdata_i = v.wdata;
    mem.mem_ack_i = 1'b0;
    #1;
    if (stall_o) n_stall++;
    @(negedge clk);
    if (v.exp_mis) begin
      chk({tag, " trap_req"}, 32'(mem.mem_req_o), 32'd0);
      chk({tag, " trap_misalign"}, 32'(misalign_o), 32'd1);
      chk({tag, " trap_lvalid"}, 32'(load_valid_o), 32'd0);
      chk({tag, " trap_stall"}, 32'(stall_o), 32'd0);
    end else begin
      chk({tag, " addr"}, mem.mem_addr_o, v.exp_addr);
      chk({tag, " wmask"}, 32'(mem.mem_wmask_o), 32'(v.exp_wmask));
      chk({tag, " wdata"}, mem.mem_wdata_o, v.exp_wdata);
      chk({tag, " we"}, 32'(mem.mem_we_o), 32'(v.we));
      for (int unsigned k = 0; k <= v.delay; k++) begin
        chk({tag, " req"}, 32'(mem.mem_req_o), 32'd1);
        if (stall_o) n_stall++;
        if (k == v.delay) begin
          mem.mem_ack_i   = 1'b1;
          mem.mem_rdata_i = v.rdata;
        end
        @(negedge clk);
        mem.mem_ack_i   = 1'b0;
        mem.mem_rdata_i = $urandom;
      end
      chk({tag, " done_req"}, 32'(mem.mem_req_o), 32'd0);
      chk({tag, " done_stall"}, 32'(stall_o), 32'd0);
      chk({tag, " lvalid"}, 32'(load_valid_o), 32'(!v.we));
      chk({tag, " misalign"}, 32'(misalign_o), 32'd0);
      if (!v.we) chk({tag, " ldata"}, load_data_o, v.exp_ld);
      chk({tag, " stall_cycles"}, n_stall, v.delay + 2);
    end
    // addr_valid_i was held through DONE; the unit must be back in IDLE, not in a new REQ
    @(negedge clk);
    chk({tag, " no_relaunch"}, 32'(mem.mem_req_o), 32'd0);
    chk({tag, " lvalid_1cyc"}, 32'(load_valid_o), 32'd0);
    addr_valid_i = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[7];
    vec_t v;
    int unsigned mk;

    reset_n_i = 1'b0; addr_valid_i = 1'b0; we_i = 1'b0; addr_i = '0;
    mask_i = '0; sext_i = 1'b0; wdata_i = '0;
    mem.mem_ack_i = 1'b0; mem.mem_rdata_i = '0;

    //           we    addr          mask     sext  wdata          rdata          dly mis   exp_addr       wmask    exp_wdata      exp_ld
    tbl[0] = '{1'b1, 32'h0000_0104, 4'b1111, 1'b0, 32'hDEAD_BEEF, 32'h0,         1, 1'b0, 32'h0000_0104, 4'b1111, 32'hDEAD_BEEF, 32'h0};
    tbl[1] = '{1'b1, 32'h0000_0203, 4'b0001, 1'b0, 32'h0000_00A5, 32'h0,         0, 1'b0, 32'h0000_0200, 4'b1000, 32'hA500_0000, 32'h0};
    tbl[2] = '{1'b0, 32'h0000_0302, 4'b0001, 1'b1, 32'h0,         32'h0080_FF11, 0, 1'b0, 32'h0000_0300, 4'b0000, 32'h0,         32'hFFFF_FF80};
    tbl[3] = '{1'b0, 32'h0000_0402, 4'b0011, 1'b0, 32'h0,         32'h8001_ABCD, 2, 1'b0, 32'h0000_0400, 4'b0000, 32'h0,         32'h0000_8001};
    tbl[4] = '{1'b0, 32'h0000_0402, 4'b0011, 1'b1, 32'h0,         32'h8001_ABCD, 0, 1'b0, 32'h0000_0400, 4'b0000, 32'h0,         32'hFFFF_8001};
`ifdef MISALIGN_TRAP_EN
    tbl[5] = '{1'b0, 32'h0000_0501, 4'b1111, 1'b0, 32'h0,         32'h1234_5678, 0, 1'b1, 32'h0,         4'b0000, 32'h0,         32'h0};
`else
    tbl[5] = '{1'b0, 32'h0000_0501, 4'b1111, 1'b0, 32'h0,         32'h1234_5678, 0, 1'b0, 32'h0000_0500, 4'b0000, 32'h0,         32'h1234_5678};
`endif
    // Unrecognised mask behaves as a word store
    tbl[6] = '{1'b1, 32'h0000_0600, 4'b0101, 1'b0, 32'h1234_5678, 32'h0,         0, 1'b0, 32'h0000_0600, 4'b1111, 32'h1234_5678, 32'h0};

    repeat (2) @(negedge clk);
    chk("rst req", 32'(mem.mem_req_o), 32'd0);
    chk("rst we", 32'(mem.mem_we_o), 32'd0);
    chk("rst addr", mem.mem_addr_o, 32'd0);
    chk("rst wmask", 32'(mem.mem_wmask_o), 32'd0);
    chk("rst wdata", mem.mem_wdata_o, 32'd0);
    chk("rst ldata", load_data_o, 32'd0);
    chk("rst lvalid", 32'(load_valid_o), 32'd0);
    chk("rst misalign", 32'(misalign_o), 32'd0);
    chk("rst stall", 32'(stall_o), 32'd0);
    reset_n_i = 1'b1;

    for (int i = 0; i < 7; i++) apply(tbl[i], $sformatf("vec%0d", i));

    for (int i = 0; i < 60; i++) begin
      v.we    = 1'($urandom_range(0, 1));
      v.addr  = $urandom;
      mk      = $urandom_range(0, 3);
      v.mask  = (mk == 0) ? 4'b0001 : (mk == 1) ? 4'b0011 : (mk == 2) ? 4'b1111 : 4'($urandom);
      v.sext  = 1'($urandom_range(0, 1));
      v.wdata = $urandom;
      v.rdata = $urandom;
      v.delay = $urandom_range(0, 3);
      apply(model(v), $sformatf("rnd%0d", i));
    end

    // Reset while the request is outstanding, then a late ack
    @(negedge clk);
    addr_valid_i = 1'b1; we_i = 1'b0; addr_i = 32'h0000_0700; mask_i = 4'b1111; sext_i = 1'b0;
    @(negedge clk);
    chk("rstmid req_before", 32'(mem.mem_req_o), 32'd1);
    reset_n_i = 1'b0;
    addr_valid_i = 1'b0;
    #1;
    chk("rstmid req_drop", 32'(mem.mem_req_o), 32'd0);
    chk("rstmid addr_clr", mem.mem_addr_o, 32'd0);
    chk("rstmid stall", 32'(stall_o), 32'd0);
    mem.mem_ack_i = 1'b1; mem.mem_rdata_i = 32'hCAFE_F00D;
    @(negedge clk);
    reset_n_i = 1'b1;
    @(negedge clk);
    mem.mem_ack_i = 1'b0;
    chk("rstmid late_ack_req", 32'(mem.mem_req_o), 32'd0);
    chk("rstmid late_ack_lvalid", 32'(load_valid_o), 32'd0);
    chk("rstmid late_ack_ldata", load_data_o, 32'd0);
    @(negedge clk);
    chk("rstmid idle_lvalid", 32'(load_valid_o), 32'd0);
    chk("rstmid idle_stall", 32'(stall_o), 32'd0);
    apply(tbl[4], "post_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
